aoi22_cell_bist: RTL and testbench

- Built-in self-test sequencer for the 12T AOI22 cell (Y = ~((A0&A1)|(B0&B1))).
- Sits directly upstream and downstream of the cell. It drives A0/A1/B0/B1 through all 16 input vectors in Gray-code order, so every step toggles exactly one input and exercises one timing arc.
- It samples Y after a programmable settle time, compares Y against the golden function, and reports pass/fail, error count and the first failing vector.
- Used on silicon test structures and in gate-level regression of the cell library.

---
 rtl/aoi22_bist_pkg.sv | 24 ++
 rtl/bist_sync2.sv | 22 ++
 rtl/aoi22_cell_bist.sv | 144 ++++++++++++++
 tb/tb_aoi22_cell_bist.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoi22_bist_pkg.sv
// Shared types and helpers for the AOI22 cell BIST sequencer.
// Provides the FSM state encoding, Gray-code vector generation and the golden cell function.
package aoi22_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] VEC_LAST = 4'd15;

    // Bit order of a vector is {A0, A1, B0, B1}.
    function automatic logic [3:0] gray4(input logic [3:0] i);
        return i ^ (i >> 1);
    endfunction

    function automatic logic aoi22_golden(input logic [3:0] vec);
        return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    endfunction

endpackage

// File: rtl/bist_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit signal.
// Both stages clear to 0 on a synchronous active-high reset.
module bist_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aoi22_cell_bist.sv
// BIST sequencer for the AOI22 cell: sweeps all 16 inputs in Gray order, samples Y
// after a settle window and records error count and the first failing vector.
module aoi22_cell_bist
    import aoi22_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5,
    parameter int LOOPS         = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             A0,
    output logic             A1,
    output logic             B0,
    output logic             B1,
    input  logic             Y,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_VEC,
    output logic [2:0]       DBG_STATE
);

    // Control protocol: START is a one-cycle request accepted only in IDLE or DONE.
    // BUSY rises on the accepting edge and falls on the edge DONE rises; DONE holds
    // with PASS/ERR_CNT/FAIL_VEC stable until the next accepted START or RST.

    localparam logic [4:0]       SETTLE_LOAD = 5'(SETTLE_CYCLES + 1);
    localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state;
    logic [3:0]       vec_q;
    logic [3:0]       idx;
    logic [7:0]       loop_cnt;
    logic [4:0]       settle_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       fail_vec;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             y_sync;
    logic             mism;

    bist_sync2 u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (Y),
        .q   (y_sync)
    );

    // Case inequality so an X/Z on Y in simulation is scored as a failure.
    always_comb begin
        mism = 1'b0;
        if (y_sync !== aoi22_golden(vec_q)) begin
            mism = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            vec_q      <= 4'd0;
            idx        <= 4'd0;
            loop_cnt   <= 8'd0;
            settle_cnt <= 5'd0;
            err_cnt    <= '0;
            fail_vec   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state    <= S_APPLY;
                        idx      <= 4'd0;
                        loop_cnt <= 8'd0;
                        err_cnt  <= '0;
                        fail_vec <= 4'd0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                S_APPLY: begin
                    vec_q      <= gray4(idx);
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == 5'd0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 5'd1;
                    end
                end
                S_CHECK: begin
                    if (mism) begin
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        // The counter never wraps back to zero, so zero means no error yet.
                        if (err_cnt == '0) begin
                            fail_vec <= vec_q;
                        end
                    end
                    if (idx == VEC_LAST) begin
                        if (loop_cnt == LOOP_LAST) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_cnt == '0) && !mism;
                        end else begin
                            loop_cnt <= loop_cnt + 8'd1;
                            idx      <= 4'd0;
                            state    <= S_APPLY;
                        end
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= S_APPLY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign A0        = vec_q[3];
    assign A1        = vec_q[2];
    assign B0        = vec_q[1];
    assign B1        = vec_q[0];
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_CNT   = err_cnt;
    assign FAIL_VEC  = fail_vec;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_aoi22_cell_bist.sv
// Self-checking bench for aoi22_cell_bist: good, stuck-at, saturation, reset-abort
// and multi-loop scenarios against behavioural cell models.
module tb_aoi22_cell_bist;
    import aoi22_bist_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: defaults, cell model selectable
    logic       start_m = 1'b0;
    logic       a0, a1, b0, b1, y_m;
    logic       busy_m, done_m, pass_m;
    logic [4:0] err_m;
    logic [3:0] fvec_m;
    logic [2:0] dbg_m;
    int         mode = 0; // 0 good, 1 stuck-at-1, 2 stuck-at-0

    assign y_m = (mode == 0) ? ~((a0 & a1) | (b0 & b1)) : (mode == 1);

    aoi22_cell_bist #(.SETTLE_CYCLES(2), .ERR_W(5), .LOOPS(1)) u_main (
        .CLK(clk), .RST(rst), .START(start_m),
        .A0(a0), .A1(a1), .B0(b0), .B1(b1), .Y(y_m),
        .BUSY(busy_m), .DONE(done_m), .PASS(pass_m),
        .ERR_CNT(err_m), .FAIL_VEC(fvec_m), .DBG_STATE(dbg_m)
    );

    // Saturation instance: ERR_W=2, cell stuck-at-0
    logic       start_s = 1'b0;
    logic       s_a0, s_a1, s_b0, s_b1;
    logic       y_s = 1'b0;
    logic       busy_s, done_s, pass_s;
    logic [1:0] err_s;
    logic [3:0] fvec_s;
    logic [2:0] dbg_s;

    aoi22_cell_bist #(.SETTLE_CYCLES(2), .ERR_W(2), .LOOPS(1)) u_sat (
        .CLK(clk), .RST(rst), .START(start_s),
        .A0(s_a0), .A1(s_a1), .B0(s_b0), .B1(s_b1), .Y(y_s),
        .BUSY(busy_s), .DONE(done_s), .PASS(pass_s),
        .ERR_CNT(err_s), .FAIL_VEC(fvec_s), .DBG_STATE(dbg_s)
    );

    // Multi-loop instance: LOOPS=3, cell stuck-at-1
    logic       start_l = 1'b0;
    logic       l_a0, l_a1, l_b0, l_b1;
    logic       y_l = 1'b1;
    logic       busy_l, done_l, pass_l;
    logic [4:0] err_l;
    logic [3:0] fvec_l;
    logic [2:0] dbg_l;

    aoi22_cell_bist #(.SETTLE_CYCLES(2), .ERR_W(5), .LOOPS(3)) u_loop (
        .CLK(clk), .RST(rst), .START(start_l),
        .A0(l_a0), .A1(l_a1), .B0(l_b0), .B1(l_b1), .Y(y_l),
        .BUSY(busy_l), .DONE(done_l), .PASS(pass_l),
        .ERR_CNT(err_l), .FAIL_VEC(fvec_l), .DBG_STATE(dbg_l)
    );

    // Scoreboard: expected vectors queued at START, popped as each CHECK is seen
    logic [3:0]  exp_q[$];
    logic [3:0]  last_vec = 4'd0;
    logic [15:0] seen = 16'd0;
    bit          first_of_run = 1'b1;

    always @(negedge clk) begin
        logic [3:0] cur;
        logic [3:0] expv;
        if (!rst && dbg_m == 3'(S_CHECK)) begin
            cur = {a0, a1, b0, b1};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_vec: got vector %b, no vector expected", cur);
            end else begin
                expv = exp_q.pop_front();
                if (cur !== expv) begin
                    errors++;
                    $display("FAIL sb_vec: got %b expected %b", cur, expv);
                end
            end
            if (!first_of_run) begin
                checks++;
                if ($countones(cur ^ last_vec) != 1) begin
                    errors++;
                    $display("FAIL one_bit_step: %b -> %b", last_vec, cur);
                end
            end
            first_of_run = 1'b0;
            last_vec = cur;
            seen[cur] = 1'b1;
        end
    end

    function automatic logic [3:0] tb_gray(input int i);
        logic [3:0] b;
        b = i[3:0];
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic logic tb_cell(input logic [3:0] v);
        return !((v[3] && v[2]) || (v[1] && v[0]));
    endfunction

    task automatic queue_sweep();
        exp_q.delete();
        seen = 16'd0;
        first_of_run = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(tb_gray(i));
    endtask

    // Pulse START on one instance and count cycles from the accepting edge to DONE.
    task automatic pulse_wait(input int which, input int bound, output int cycles,
                              output logic busy_seen, output bit timed_out);
        logic d;
        @(negedge clk);
        case (which)
            0: start_m = 1'b1;
            1: start_s = 1'b1;
            default: start_l = 1'b1;
        endcase
        @(posedge clk); #1;
        start_m = 1'b0; start_s = 1'b0; start_l = 1'b0;
        busy_seen = (which == 0) ? busy_m : (which == 1) ? busy_s : busy_l;
        cycles = 0;
        d = 1'b0;
        while (!d && cycles < bound) begin
            @(posedge clk); #1;
            cycles++;
            d = (which == 0) ? done_m : (which == 1) ? done_s : done_l;
        end
        timed_out = !d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a0, a1, b0, b1, busy_m, done_m, pass_m} !== 7'd0 || err_m !== 5'd0 ||
            fvec_m !== 4'd0 || dbg_m !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL reset_values: vec=%b busy=%b done=%b pass=%b err=%0d fvec=%b st=%0d",
                     {a0, a1, b0, b1}, busy_m, done_m, pass_m, err_m, fvec_m, dbg_m);
        end
        // START together with RST must be overridden by reset
        @(negedge clk);
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        checks++;
        if (busy_m !== 1'b0 || dbg_m !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL rst_beats_start: busy=%b st=%0d expected busy=0 st=0", busy_m, dbg_m);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_good_sweep(input string tag);
        int cyc; logic bz; bit to;
        mode = 0;
        queue_sweep();
        pulse_wait(0, 3000, cyc, bz, to);
        checks++;
        if (bz !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b expected 1", tag, bz);
        end
        checks++;
        if (to || cyc != 96) begin
            errors++; $display("FAIL %s run_length: got %0d timeout=%0b expected 96", tag, cyc, to);
        end
        checks++;
        if (pass_m !== 1'b1 || err_m !== 5'd0 || fvec_m !== 4'd0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL %s good_result: pass=%b err=%0d fvec=%b busy=%b expected 1/0/0000/0",
                     tag, pass_m, err_m, fvec_m, busy_m);
        end
        checks++;
        if (exp_q.size() != 0 || seen !== 16'hFFFF) begin
            errors++;
            $display("FAIL %s coverage: left=%0d seen=%h expected 0/ffff", tag, exp_q.size(), seen);
        end
        checks++;
        if ({a0, a1, b0, b1} !== 4'b1000) begin
            errors++; $display("FAIL %s final_vec: got %b expected 1000", tag, {a0, a1, b0, b1});
        end
    endtask

    task automatic test_stuck1();
        int cyc; logic bz; bit to;
        int exp_err; logic [3:0] exp_fv; bit found;
        exp_err = 0; exp_fv = 4'd0; found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tb_cell(tb_gray(i)) !== 1'b1) begin
                exp_err++;
                if (!found) begin exp_fv = tb_gray(i); found = 1'b1; end
            end
        end
        mode = 1;
        queue_sweep();
        pulse_wait(0, 3000, cyc, bz, to);
        checks++;
        if (to || cyc != 96) begin
            errors++; $display("FAIL stuck1_length: got %0d timeout=%0b expected 96", cyc, to);
        end
        checks++;
        if (err_m !== 5'(exp_err) || exp_err != 7) begin
            errors++; $display("FAIL stuck1_err_cnt: got %0d expected %0d", err_m, exp_err);
        end
        checks++;
        if (pass_m !== 1'b0 || fvec_m !== exp_fv || exp_fv !== 4'b0011) begin
            errors++;
            $display("FAIL stuck1_result: pass=%b fvec=%b expected 0/%b", pass_m, fvec_m, exp_fv);
        end
        mode = 0;
    endtask

    task automatic test_saturate();
        int cyc; logic bz; bit to;
        pulse_wait(1, 3000, cyc, bz, to);
        checks++;
        if (to || err_s !== 2'd3 || pass_s !== 1'b0 || fvec_s !== 4'b0000) begin
            errors++;
            $display("FAIL saturate: err=%0d pass=%b fvec=%b timeout=%0b expected 3/0/0000",
                     err_s, pass_s, fvec_s, to);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        mode = 0;
        queue_sweep();
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        n = 0;
        while (!(dbg_m == 3'(S_SETTLE) && {a0, a1, b0, b1} == tb_gray(5)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++; $display("FAIL reach_vec5_settle: timeout after %0d cycles", n);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a0, a1, b0, b1, busy_m, done_m, pass_m} !== 7'd0 || err_m !== 5'd0 ||
            fvec_m !== 4'd0 || dbg_m !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL abort_reset: vec=%b busy=%b done=%b pass=%b err=%0d fvec=%b st=%0d",
                     {a0, a1, b0, b1}, busy_m, done_m, pass_m, err_m, fvec_m, dbg_m);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        test_good_sweep("after_abort");
    endtask

    task automatic test_loops_ignore_start();
        int cyc; bit d;
        @(negedge clk);
        start_l = 1'b1;
        @(posedge clk); #1;
        start_l = 1'b0;
        cyc = 0; d = 1'b0;
        while (!d && cyc < 5000) begin
            if (cyc == 50) begin
                @(negedge clk);
                start_l = 1'b1;
            end
            @(posedge clk); #1;
            start_l = 1'b0;
            cyc++;
            d = done_l;
        end
        checks++;
        if (!d || cyc != 288) begin
            errors++; $display("FAIL loops_length: got %0d done=%0b expected 288", cyc, d);
        end
        checks++;
        if (err_l !== 5'd21 || pass_l !== 1'b0 || fvec_l !== 4'b0011) begin
            errors++;
            $display("FAIL loops_result: err=%0d pass=%b fvec=%b expected 21/0/0011",
                     err_l, pass_l, fvec_l);
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep("first");
        test_stuck1();
        test_good_sweep("back_to_back");
        test_saturate();
        test_reset_mid_run();
        test_loops_ignore_start();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
